router_output_ctrl: RTL and testbench
=====================================

Name: router_output_ctrl

Overview:
- Output-port control for the 3-port ring router; the counterpart of the per-input request logic.
- Collects one request bit from each of the three input controls (west/terminal/east order, bits 0/1/2) that target this output port.
- Arbitrates among them round-robin and returns one-hot grants. The granted input's in_rdy asserts that same cycle through the AND-OR of reqs and grants.
- Manages a single-entry output pipeline register (datapath held elsewhere) with val/rdy toward the downstream channel.

Parameters:
- p_num_ports, 3, number of requesters; fixed at 3 for this router, parameterised only for width derivation.
- p_init_priority, 3'b001, one-hot port holding highest priority out of reset.
- c_sel_nbits, $clog2(p_num_ports), width of mux select; not set externally.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- reqs  input  3  request bit from each input control for this output port.
- grants  output  3  one-hot grant back to input controls; 0 when no grant.
- sel  output  2  binary index of granted port for datapath input mux; 0 when no grant.
- reg_en  output  1  load enable for output data register; equals |grants.
- out_val  output  1  output register holds a valid message.
- out_rdy  input  1  downstream accepts message this cycle.

Behaviour:
- State: full (1b), prio (3b one-hot). Async reset (reset=0) -> full=0, prio=p_init_priority.
- While reset asserted: grants=0, reg_en=0, sel=0, out_val=0, regardless of reqs.
- can_accept = !full || out_rdy (bypass of drain: a message leaving and a new one loading in the same cycle is allowed).
- Arbitration (combinational): if can_accept, scan ports starting at index of prio, wrapping 2->0. Grant the first with reqs bit set. Else grants=0.
- At most one grants bit set, and only for a port whose reqs bit is 1.
- sel = index of granted bit (001->0, 010->1, 100->2), else 0. reg_en = |grants.
- Latency: message granted in cycle N appears with out_val=1 in cycle N+1.
- Next full = reg_en || (full && !out_rdy).
- out_val = full (registered, no combinational path from reqs or out_rdy).
- Priority update: on posedge with reg_en=1 and granted index i, prio <= one-hot (i+1) mod 3. Unchanged when no grant, including when blocked by !can_accept.
- Full and !out_rdy: grants=0, prio and full held. Requests stay pending; inputs must hold val (input side holds until in_rdy).
- Full and out_rdy with a request: drain and reload same cycle; out_val stays 1.
- Full and out_rdy with no request: full->0.
- Empty and no request: stays empty, outputs 0.
- reqs is combinational from input val/dest. grants may depend combinationally on reqs, full, out_rdy, and prio only. No loop through in_rdy.
- Reset asserted mid-transfer: buffered message is discarded (full=0). Priority returns to p_init_priority immediately (async).

Test Plan:
- Reset: reset=0 with reqs=111, out_rdy=1 -> grants=000, out_val=0. Release; first cycle reqs=111 -> grants=001, sel=0, reg_en=1, next cycle out_val=1.
- Round-robin fairness: reqs=111 held, out_rdy=1 for 6 cycles -> grants sequence 001,010,100,001,010,100; out_val=1 from cycle 2 onward.
- Backpressure: load one message, out_rdy=0, reqs=010 for 4 cycles -> grants=000, out_val=1 held, prio unchanged. Raise out_rdy -> grants=010 same cycle, out_val stays 1.
- Skip idle ports: prio=010, reqs=101 -> grants=100, sel=2. Next cycle reqs=101 -> grants=001, sel=0.
- Drain to empty: full, out_rdy=1, reqs=000 -> next cycle out_val=0. Then with out_rdy=0 and empty, reqs=100 -> grants=100 (empty accepts regardless of out_rdy).
- Async reset mid-operation: full=1, prio=100, drop reset between edges -> out_val=0 immediately. After release, reqs=111 -> grants=001.

Source files
------------

// File: rtl/router_output_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_output_ctrl
//  Description : Output-port control for the 3-port ring router. It arbitrates
//                round-robin among the input controls that target this output,
//                returns one-hot grants and the mux select, and tracks the
//                single-entry output pipeline register (val/rdy downstream).
//  Revision    : 1.0 - initial release
// ============================================================================
module router_output_ctrl #(
    parameter int                     p_num_ports     = 3,
    parameter logic [p_num_ports-1:0] p_init_priority = {{(p_num_ports-1){1'b0}}, 1'b1}
) (
    input  logic                           clk,
    input  logic                           reset,     // asynchronous, active-low
    input  logic [p_num_ports-1:0]         reqs,
    output logic [p_num_ports-1:0]         grants,
    output logic [$clog2(p_num_ports)-1:0] sel,
    output logic                           reg_en,
    output logic                           out_val,
    input  logic                           out_rdy
);

    localparam int c_sel_nbits = $clog2(p_num_ports);

    logic                     full_q;
    logic                     full_d;
    logic [p_num_ports-1:0]   prio_q;
    logic [p_num_ports-1:0]   prio_d;

    logic                     w_can_accept;
    logic [c_sel_nbits-1:0]   w_prio_idx;
    logic [2*p_num_ports-1:0] w_reqs_rot_dbl;
    logic [p_num_ports-1:0]   w_reqs_rot;
    logic [p_num_ports-1:0]   w_pick_rot;
    logic [2*p_num_ports-1:0] w_pick_dbl;
    logic [p_num_ports-1:0]   w_grants_raw;

    // A slot is free when empty, or when the held message drains this cycle.
    assign w_can_accept = !full_q || out_rdy;

    // Binary index of the one-hot priority pointer.
    always_comb begin
        w_prio_idx = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            if (prio_q[i]) begin
                w_prio_idx = c_sel_nbits'(i);
            end
        end
    end

    // Rotate requests so the priority port sits at bit 0, pick the lowest set
    // bit, then rotate the pick back: this scans from prio with wrap-around.
    always_comb begin
        w_reqs_rot_dbl = {reqs, reqs} >> w_prio_idx;
        w_reqs_rot     = w_reqs_rot_dbl[p_num_ports-1:0];
        w_pick_rot     = '0;
        for (int i = p_num_ports - 1; i >= 0; i--) begin
            if (w_reqs_rot[i]) begin
                w_pick_rot    = '0;
                w_pick_rot[i] = 1'b1;
            end
        end
        w_pick_dbl   = {w_pick_rot, w_pick_rot} << w_prio_idx;
        w_grants_raw = w_can_accept ? w_pick_dbl[2*p_num_ports-1:p_num_ports] : '0;
    end

    // Grants are suppressed while reset is held so nothing loads during reset.
    always_comb begin
        grants = reset ? w_grants_raw : '0;
        sel    = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            if (grants[i]) begin
                sel = c_sel_nbits'(i);
            end
        end
        reg_en = |grants;
    end

    // Next state: load on grant, otherwise drain when downstream accepts;
    // priority moves to the port after the winner only when a grant happens.
    always_comb begin
        full_d = reg_en || (full_q && !out_rdy);
        prio_d = reg_en ? {grants[p_num_ports-2:0], grants[p_num_ports-1]} : prio_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            prio_q <= p_init_priority;
        end else begin
            full_q <= full_d;
            prio_q <= prio_d;
        end
    end

    assign out_val = full_q;

endmodule
`default_nettype wire

// File: tb/tb_router_output_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_output_ctrl
//  Description : Directed self-checking bench for router_output_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_output_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] reqs;
    logic [2:0] grants;
    logic [1:0] sel;
    logic       reg_en;
    logic       out_val;
    logic       out_rdy;

    int errors;
    int checks;

    router_output_ctrl #(
        .p_num_ports     (3),
        .p_init_priority (3'b001)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .reqs    (reqs),
        .grants  (grants),
        .sel     (sel),
        .reg_en  (reg_en),
        .out_val (out_val),
        .out_rdy (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Apply inputs just after an edge, then check combinational outputs mid-cycle.
    task automatic drive(input logic [2:0] r, input logic rdy);
        reqs    = r;
        out_rdy = rdy;
        #2;
    endtask

    // One cycle: drive, check grant/sel/reg_en and the current out_val.
    task automatic cyc(input string tag, input logic [2:0] r, input logic rdy,
                       input logic [2:0] eg, input logic [1:0] es, input logic ev);
        drive(r, rdy);
        chk({tag, ".grants"}, 8'(grants), 8'(eg));
        chk({tag, ".sel"},    8'(sel),    8'(es));
        chk({tag, ".reg_en"}, 8'(reg_en), 8'(|eg));
        chk({tag, ".out_val"}, 8'(out_val), 8'(ev));
        next_cycle();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        reqs    = 3'b111;
        out_rdy = 1'b1;

        // Reset held with requests present: everything quiet.
        repeat (3) next_cycle();
        #2;
        chk("rst.grants",  8'(grants),  8'h0);
        chk("rst.reg_en",  8'(reg_en),  8'h0);
        chk("rst.sel",     8'(sel),     8'h0);
        chk("rst.out_val", 8'(out_val), 8'h0);
        next_cycle();
        reset = 1'b1;

        // First grant after reset goes to port 0; then round-robin.
        cyc("rr0", 3'b111, 1'b1, 3'b001, 2'd0, 1'b0);
        cyc("rr1", 3'b111, 1'b1, 3'b010, 2'd1, 1'b1);
        cyc("rr2", 3'b111, 1'b1, 3'b100, 2'd2, 1'b1);
        cyc("rr3", 3'b111, 1'b1, 3'b001, 2'd0, 1'b1);
        cyc("rr4", 3'b111, 1'b1, 3'b010, 2'd1, 1'b1);
        cyc("rr5", 3'b111, 1'b1, 3'b100, 2'd2, 1'b1);
        // prio now 001, full.

        // Backpressure: full and downstream stalled, request on port 1 waits.
        cyc("bp0", 3'b010, 1'b0, 3'b000, 2'd0, 1'b1);
        cyc("bp1", 3'b010, 1'b0, 3'b000, 2'd0, 1'b1);
        cyc("bp2", 3'b010, 1'b0, 3'b000, 2'd0, 1'b1);
        cyc("bp3", 3'b010, 1'b0, 3'b000, 2'd0, 1'b1);
        // Downstream ready: drain and reload in the same cycle.
        cyc("bp4", 3'b010, 1'b1, 3'b010, 2'd1, 1'b1);
        // prio now 100.

        // Bring prio to 010, then skip idle port 1.
        cyc("sk0", 3'b001, 1'b1, 3'b001, 2'd0, 1'b1);
        cyc("sk1", 3'b101, 1'b1, 3'b100, 2'd2, 1'b1);
        cyc("sk2", 3'b101, 1'b1, 3'b001, 2'd0, 1'b1);
        // prio now 010, full.

        // Drain to empty, then an empty slot accepts regardless of out_rdy.
        cyc("dr0", 3'b000, 1'b1, 3'b000, 2'd0, 1'b1);
        cyc("dr1", 3'b100, 1'b0, 3'b100, 2'd2, 1'b0);
        // prio now 001, full.
        cyc("dr2", 3'b010, 1'b1, 3'b010, 2'd1, 1'b1);
        // prio now 100, full.

        // Async reset between edges discards the message immediately.
        drive(3'b000, 1'b0);
        chk("ar.pre_val", 8'(out_val), 8'h1);
        reset = 1'b0;
        #1;
        chk("ar.out_val", 8'(out_val), 8'h0);
        chk("ar.grants_in_rst", 8'(grants), 8'h0);
        next_cycle();
        #2;
        reset = 1'b1;
        next_cycle();
        // Priority back to port 0 even though it was 100 before reset.
        cyc("ar1", 3'b111, 1'b1, 3'b001, 2'd0, 1'b0);
        cyc("ar2", 3'b000, 1'b1, 3'b000, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
